// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding,
// the debug state width and a helper that sizes the shared cycle counter.
package reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_SOFT      = 3'd4
    } seq_state_e;

    // One counter serves the stage spacing, the soft-reset hold and the lock filter
    function automatic int cnt_width(input int stageDelay, input int softCyc, input int lockFilter);
        int maxVal;
        maxVal = stageDelay;
        if (softCyc > maxVal) begin
            maxVal = softCyc;
        end
        if (lockFilter > maxVal) begin
            maxVal = lockFilter;
        end
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Multi-flop synchronizer. ASYNC_CLR=1 builds a reset synchronizer (shifts in 1,
// async assert / sync deassert); ASYNC_CLR=0 synchronizes d_i, cleared only by rst_n_i.
module rst_sync_cell #(
    parameter int SYNC_STAGES = 2,
    parameter bit ASYNC_CLR   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic                   shiftIn;
    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    assign shiftIn = ASYNC_CLR ? 1'b1 : d_i;
    assign chain_d = {chain_q[SYNC_STAGES-2:0], shiftIn};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release gated by PLL lock, with soft reset and lock-loss re-sequencing.
// Optional macro RST_SEQ_LOCK_FILTER_EN adds a consecutive-cycle lock filter in S_WAIT_LOCK.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int STAGE_DELAY  = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int SOFT_RST_CYC = 8,
    parameter int LOCK_FILTER  = 32
) (
    input  logic                  clk_In,
    input  logic                  rst_n_In,
    input  logic                  pll_lock_In,
    input  logic                  soft_rst_req_In,
    output logic [NUM_STAGES-1:0] rst_n_stage_Out,
    output logic                  seq_done_Out,
    output logic [STATE_W-1:0]    state_Out
);

    localparam int CNT_W = cnt_width(STAGE_DELAY, SOFT_RST_CYC, LOCK_FILTER);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0]      STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]      SOFT_LAST  = CNT_W'(SOFT_RST_CYC - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);
`ifdef RST_SEQ_LOCK_FILTER_EN
    localparam logic [CNT_W-1:0]      FILT_LAST  = CNT_W'(LOCK_FILTER - 1);
`endif

    logic rstSync;
    logic lockSync;

    seq_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_STAGES-1:0] stage_q;
    logic                  done_q;

    rst_sync_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .ASYNC_CLR   (1'b1)
    ) u_rst_sync (
        .clk_i   (clk_In),
        .rst_n_i (rst_n_In),
        .d_i     (1'b1),
        .q_o     (rstSync)
    );

    rst_sync_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .ASYNC_CLR   (1'b0)
    ) u_lock_sync (
        .clk_i   (clk_In),
        .rst_n_i (rst_n_In),
        .d_i     (pll_lock_In),
        .q_o     (lockSync)
    );

    // Lock loss is checked ahead of everything else, so it beats a same-cycle soft request
    always_ff @(posedge clk_In or negedge rst_n_In) begin
        if (!rst_n_In) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    stage_q <= '0;
                    done_q  <= 1'b0;
                    if (rstSync) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end

                S_WAIT_LOCK: begin
                    stage_q <= '0;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
`ifdef RST_SEQ_LOCK_FILTER_EN
                    if (!lockSync) begin
                        cnt_q <= '0;
                    end else if (cnt_q == FILT_LAST) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
`else
                    if (lockSync) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                    end
`endif
                end

                S_RELEASE: begin
                    if (!lockSync) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        stage_q <= '0;
                        done_q  <= 1'b0;
                    end else if (cnt_q == STAGE_LAST) begin
                        stage_q <= stage_q | (STAGE_ONE << idx_q);
                        cnt_q   <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_RUN;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_RUN: begin
                    if (!lockSync) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        stage_q <= '0;
                        done_q  <= 1'b0;
                    end else if (soft_rst_req_In) begin
                        state_q <= S_SOFT;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        stage_q <= '0;
                        done_q  <= 1'b0;
                    end
                end

                S_SOFT: begin
                    stage_q <= '0;
                    done_q  <= 1'b0;
                    if (cnt_q == SOFT_LAST) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    stage_q <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_n_stage_Out = stage_q;
    assign seq_done_Out    = done_q;
    assign state_Out       = state_q;

endmodule
